// File: rtl/shr_seq.sv
// Purpose : multicycle LSR/ASR unit, one bit of right shift per clock under start/done.
// Latency : shamt+1 cycles from the accepted start edge to the done pulse.
// Backpressure: none; start is only sampled in IDLE and ignored while busy.
//
// Ports:
//   clk    - system clock, rising-edge state updates
//   reset  - asynchronous active-low reset; clears all state
//   start  - operation request, sampled only in IDLE
//   a      - operand, sampled with start
//   shamt  - shift distance 0..N-1, sampled with start
//   arith  - 1 = sign fill (ASR), 0 = zero fill (LSR), sampled with start
//   busy   - high whenever the unit is not idle
//   done   - one-cycle pulse; y is valid while it is high
//   y      - result register, held until the next accepted start
module shr_seq #(
  parameter int N  = 64,
  parameter int SW = $clog2(N)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [N-1:0]  a,
  input  logic [SW-1:0] shamt,
  input  logic          arith,
  output logic          busy,
  output logic          done,
  output logic [N-1:0]  y
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } st_t;

  localparam logic [SW-1:0] CNT_ONE = SW'(1);

  st_t           st;
  logic [N-1:0]  r;
  logic [SW-1:0] cnt;
  logic          m;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      st  <= IDLE;
      r   <= '0;
      cnt <= '0;
      m   <= 1'b0;
    end else begin
      case (st)
        IDLE: begin
          if (start) begin
            r   <= a;
            cnt <= shamt;
            m   <= arith;
            // A zero-distance shift has nothing to do; report it next cycle.
            st  <= (shamt != '0) ? SHIFT : DONE;
          end
        end
        SHIFT: begin
          // Fill bit is the current MSB for ASR, zero for LSR.
          r   <= {m & r[N-1], r[N-1:1]};
          cnt <= cnt - CNT_ONE;
          // Last shift when one step remains; cnt lands on zero entering DONE.
          if (cnt == CNT_ONE) begin
            st <= DONE;
          end
        end
        DONE: begin
          st <= IDLE;
        end
        default: begin
          st <= IDLE;
        end
      endcase
    end
  end

  // Decoded from registered state only; no input-to-output path.
  assign done = (st == DONE);
  assign busy = (st != IDLE);
  assign y    = r;

endmodule

// File: tb/tb_shr_seq.sv
// Purpose : self-checking bench for shr_seq (directed plus randomized operations).
// Latency : checks done arrives shamt+1 cycles after the start edge.
// Backpressure: also checks that starts issued while busy are ignored.
module tb_shr_seq;

  localparam int N  = 64;
  localparam int SW = 6;

  logic          clk;
  logic          reset;
  logic          start;
  logic [N-1:0]  a;
  logic [SW-1:0] shamt;
  logic          arith;
  logic          busy;
  logic          done;
  logic [N-1:0]  y;

  int errors = 0;
  int checks = 0;

  shr_seq #(.N(N)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .a     (a),
    .shamt (shamt),
    .arith (arith),
    .busy  (busy),
    .done  (done),
    .y     (y)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [N-1:0] got, input logic [N-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference: the architectural meaning of LSR/ASR.
  function automatic logic [N-1:0] ref_shr(input logic [N-1:0] av, input int sh, input bit ar);
    if (ar) return N'($signed(av) >>> sh);
    else    return av >> sh;
  endfunction

  // Issue one operation and follow it through its done pulse. With noise set,
  // start/a/shamt/arith are scrambled every cycle while the unit is busy.
  task automatic run_op(input logic [N-1:0] av, input int sh, input bit ar, input bit noise);
    logic [N-1:0] exp;
    int  k;
    bit  seen;
    exp = ref_shr(av, sh, ar);
    @(negedge clk);
    a = av; shamt = SW'(sh); arith = ar; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    k = 1;
    seen = 1'b0;
    while (k <= N + 4) begin
      if (done) begin
        seen = 1'b1;
        break;
      end
      if (!busy) break;
      if (noise) begin
        a = {$urandom, $urandom};
        shamt = SW'($urandom);
        arith = 1'($urandom);
        start = 1'($urandom);
      end
      @(negedge clk);
      k++;
    end
    chk("done_seen", N'(seen), N'(1));
    chk("latency", N'(k), N'(sh + 1));
    chk("y_result", y, exp);
    chk("busy_in_done", N'(busy), N'(1));
    if (noise) begin
      a = N'(1); shamt = '0; start = 1'b1;
    end
    @(negedge clk);
    start = 1'b0;
    chk("done_one_cycle", N'(done), N'(0));
    chk("busy_fall", N'(busy), N'(0));
    chk("y_hold", y, exp);
  endtask

  initial begin
    int dn;
    reset = 1'b1; start = 1'b0; a = '0; shamt = '0; arith = 1'b0;

    // Asynchronous reset before any clock edge.
    #1 reset = 1'b0;
    #1;
    chk("rst_y", y, '0);
    chk("rst_busy", N'(busy), N'(0));
    chk("rst_done", N'(done), N'(0));
    @(negedge clk);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    chk("idle_y", y, '0);
    chk("idle_busy", N'(busy), N'(0));
    chk("idle_done", N'(done), N'(0));

    // Directed operations.
    run_op(64'd1, 0, 1'b0, 1'b0);
    run_op(64'd20, 2, 1'b0, 1'b0);
    run_op(64'd16, 2, 1'b0, 1'b0);
    run_op(64'hFFFF_FFFF_FFFF_FFFF, 63, 1'b0, 1'b0);
    run_op(64'h8000_0000_0000_0000, 4, 1'b1, 1'b0);
    run_op(64'h8000_0000_0000_0000, 4, 1'b0, 1'b0);
    run_op(64'h7000_0000_0000_0000, 4, 1'b1, 1'b0);
    run_op(64'hFFFF_FFFF_FFFF_FFFF, 63, 1'b1, 1'b0);
    run_op(64'd64, 3, 1'b0, 1'b1);

    // Reset in the middle of a 10-bit shift.
    @(negedge clk);
    a = 64'hFF; shamt = SW'(10); arith = 1'b0; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(posedge clk);
    #2 reset = 1'b0;
    #1;
    chk("abort_y", y, '0);
    chk("abort_busy", N'(busy), N'(0));
    chk("abort_done", N'(done), N'(0));
    dn = 0;
    repeat (3) begin
      @(negedge clk);
      if (done || busy) dn++;
    end
    reset = 1'b1;
    repeat (12) begin
      @(negedge clk);
      if (done || busy) dn++;
    end
    chk("abort_no_done", N'(dn), N'(0));
    run_op(64'hFF, 4, 1'b0, 1'b0);

    // Randomized operations, some with scrambled inputs while busy.
    for (int i = 0; i < 40; i++) begin
      logic [N-1:0] rv;
      int           rs;
      bit           ra;
      bit           rn;
      rv = {$urandom, $urandom};
      rs = int'($urandom_range(0, N - 1));
      ra = 1'($urandom);
      rn = 1'($urandom);
      if (i % 5 == 0) rv[N-1] = 1'b1;
      run_op(rv, rs, ra, rn);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
